// File: rtl/pos_gen_pkg.sv
// Shared types, constants and the slot-to-pixel mapping for the memory-game card position generator.
package pos_gen_pkg;

  typedef enum logic [1:0] {INIT, SHUFFLE, LOAD, DONE} state_t;

  typedef logic [3:0] slot_t;
  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } xy_t;

  // Galois feedback mask for the x^16 + x^14 + x^13 + x^11 + 1 polynomial (right-shifting form)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Slot bits [1:0] select the grid column, bits [3:2] the grid row
  function automatic xy_t slot_to_xy(input slot_t slot, input coord_t x_origin, input coord_t y_origin,
                                     input coord_t x_pitch, input coord_t y_pitch);
    xy_t xy;
    xy.x = x_origin + coord_t'(slot[1:0]) * x_pitch;
    xy.y = y_origin + coord_t'(slot[3:2]) * y_pitch;
    return xy;
  endfunction

  // Smallest all-ones mask covering k, so rejection sampling wastes at most half the draws
  function automatic slot_t shuffle_mask(input slot_t k);
    if (k[3])      return 4'hF;
    else if (k[2]) return 4'h7;
    else if (k[1]) return 4'h3;
    else           return 4'h1;
  endfunction

endpackage

// File: rtl/pos_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is swapped for the default so the register never locks up.
module pos_lfsr16
  import pos_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  localparam logic [15:0] LOAD_SEED = (SEED == 16'd0) ? DEFAULT_SEED : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_SEED;
    else        state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'd0);
  end

endmodule

// File: rtl/card_pos_generator.sv
// Shuffles 16 card slots on a 4x4 grid with an LFSR-driven Fisher-Yates pass and publishes the pixel positions.
// Define POSGEN_RESHUFFLE_EN to add a reshuffle input that restarts the shuffle from the DONE state.
module card_pos_generator
  import pos_gen_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          X_ORIGIN = 80,
  parameter int          Y_ORIGIN = 40,
  parameter int          X_PITCH  = 120,
  parameter int          Y_PITCH  = 110
)(
  input  logic       FPGA_Clk,
  input  logic       FPGA_Rst_n,
`ifdef POSGEN_RESHUFFLE_EN
  input  logic       reshuffle,
`endif
  output logic [9:0] card1X, card2X, card3X, card4X, card5X, card6X, card7X, card8X,
  output logic [9:0] card9X, card10X, card11X, card12X, card13X, card14X, card15X, card16X,
  output logic [9:0] card1Y, card2Y, card3Y, card4Y, card5Y, card6Y, card7Y, card8Y,
  output logic [9:0] card9Y, card10Y, card11Y, card12Y, card13Y, card14Y, card15Y, card16Y,
  output logic [3:0] c,
  output logic       d,
  output logic       e
);

  localparam coord_t XO = coord_t'(X_ORIGIN);
  localparam coord_t YO = coord_t'(Y_ORIGIN);
  localparam coord_t XP = coord_t'(X_PITCH);
  localparam coord_t YP = coord_t'(Y_PITCH);

  state_t      state;
  slot_t       k;
  slot_t       r;
  slot_t       perm     [16];
  coord_t      card_x   [16];
  coord_t      card_y   [16];
  xy_t         perm_xy  [16];
  xy_t         ident_xy [16];
  logic [15:0] lfsr;
  logic        unused_lfsr;

  pos_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (FPGA_Clk),
    .rst_n (FPGA_Rst_n),
    .state (lfsr)
  );

  assign c           = lfsr[3:0];
  assign unused_lfsr = &{1'b0, lfsr[15:4]};
  assign r           = c & shuffle_mask(k);

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      perm_xy[i]  = slot_to_xy(perm[i], XO, YO, XP, YP);
      ident_xy[i] = slot_to_xy(slot_t'(i), XO, YO, XP, YP);
    end
  end

  // Draws with r > k are rejected and retried on the next LFSR value, keeping the shuffle unbiased
  always_ff @(posedge FPGA_Clk or negedge FPGA_Rst_n) begin
    if (!FPGA_Rst_n) begin
      state <= INIT;
      k     <= 4'd15;
      d     <= 1'b0;
      e     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        perm[i]   <= slot_t'(i);
        card_x[i] <= ident_xy[i].x;
        card_y[i] <= ident_xy[i].y;
      end
    end else begin
      case (state)
        INIT: begin
          d     <= 1'b1;
          state <= SHUFFLE;
        end
        SHUFFLE: begin
          if (r <= k) begin
            perm[k] <= perm[r];
            perm[r] <= perm[k];
            if (k == 4'd1) state <= LOAD;
            else           k     <= k - 4'd1;
          end
        end
        LOAD: begin
          for (int i = 0; i < 16; i++) begin
            card_x[i] <= perm_xy[i].x;
            card_y[i] <= perm_xy[i].y;
          end
          d     <= 1'b0;
          e     <= 1'b1;
          state <= DONE;
        end
`ifdef POSGEN_RESHUFFLE_EN
        DONE: begin
          if (reshuffle) begin
            k     <= 4'd15;
            d     <= 1'b1;
            e     <= 1'b0;
            state <= SHUFFLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign card1X  = card_x[0];   assign card1Y  = card_y[0];
  assign card2X  = card_x[1];   assign card2Y  = card_y[1];
  assign card3X  = card_x[2];   assign card3Y  = card_y[2];
  assign card4X  = card_x[3];   assign card4Y  = card_y[3];
  assign card5X  = card_x[4];   assign card5Y  = card_y[4];
  assign card6X  = card_x[5];   assign card6Y  = card_y[5];
  assign card7X  = card_x[6];   assign card7Y  = card_y[6];
  assign card8X  = card_x[7];   assign card8Y  = card_y[7];
  assign card9X  = card_x[8];   assign card9Y  = card_y[8];
  assign card10X = card_x[9];   assign card10Y = card_y[9];
  assign card11X = card_x[10];  assign card11Y = card_y[10];
  assign card12X = card_x[11];  assign card12Y = card_y[11];
  assign card13X = card_x[12];  assign card13Y = card_y[12];
  assign card14X = card_x[13];  assign card14Y = card_y[13];
  assign card15X = card_x[14];  assign card15Y = card_y[14];
  assign card16X = card_x[15];  assign card16Y = card_y[15];

endmodule

// File: tb/tb_card_pos_generator.sv
// Directed bench for card_pos_generator: three seeds (ACE1, 0, 1234) share one clock and reset.
module tb_card_pos_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
`ifdef POSGEN_RESHUFFLE_EN
  logic       reshuffle = 1'b0;
`endif
  logic [9:0] ax [16], ay [16], zx [16], zy [16], bx [16], by [16];
  logic [3:0] c_a, c_z, c_b;
  logic       d_a, d_z, d_b, e_a, e_z, e_b;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc_a, cyc_b;
  logic [63:0] perm_a, perm_b;
  logic [9:0]  snap_x [16], snap_y [16];

  always #5 clk = ~clk;

  card_pos_generator #(.SEED(16'hACE1)) dut_a (.FPGA_Clk(clk), .FPGA_Rst_n(rst_n),
`ifdef POSGEN_RESHUFFLE_EN
    .reshuffle(reshuffle),
`endif
    .card1X(ax[0]), .card2X(ax[1]), .card3X(ax[2]), .card4X(ax[3]), .card5X(ax[4]), .card6X(ax[5]),
    .card7X(ax[6]), .card8X(ax[7]), .card9X(ax[8]), .card10X(ax[9]), .card11X(ax[10]), .card12X(ax[11]),
    .card13X(ax[12]), .card14X(ax[13]), .card15X(ax[14]), .card16X(ax[15]),
    .card1Y(ay[0]), .card2Y(ay[1]), .card3Y(ay[2]), .card4Y(ay[3]), .card5Y(ay[4]), .card6Y(ay[5]),
    .card7Y(ay[6]), .card8Y(ay[7]), .card9Y(ay[8]), .card10Y(ay[9]), .card11Y(ay[10]), .card12Y(ay[11]),
    .card13Y(ay[12]), .card14Y(ay[13]), .card15Y(ay[14]), .card16Y(ay[15]),
    .c(c_a), .d(d_a), .e(e_a));

  card_pos_generator #(.SEED(16'h0000)) dut_z (.FPGA_Clk(clk), .FPGA_Rst_n(rst_n),
`ifdef POSGEN_RESHUFFLE_EN
    .reshuffle(reshuffle),
`endif
    .card1X(zx[0]), .card2X(zx[1]), .card3X(zx[2]), .card4X(zx[3]), .card5X(zx[4]), .card6X(zx[5]),
    .card7X(zx[6]), .card8X(zx[7]), .card9X(zx[8]), .card10X(zx[9]), .card11X(zx[10]), .card12X(zx[11]),
    .card13X(zx[12]), .card14X(zx[13]), .card15X(zx[14]), .card16X(zx[15]),
    .card1Y(zy[0]), .card2Y(zy[1]), .card3Y(zy[2]), .card4Y(zy[3]), .card5Y(zy[4]), .card6Y(zy[5]),
    .card7Y(zy[6]), .card8Y(zy[7]), .card9Y(zy[8]), .card10Y(zy[9]), .card11Y(zy[10]), .card12Y(zy[11]),
    .card13Y(zy[12]), .card14Y(zy[13]), .card15Y(zy[14]), .card16Y(zy[15]),
    .c(c_z), .d(d_z), .e(e_z));

  card_pos_generator #(.SEED(16'h1234)) dut_b (.FPGA_Clk(clk), .FPGA_Rst_n(rst_n),
`ifdef POSGEN_RESHUFFLE_EN
    .reshuffle(reshuffle),
`endif
    .card1X(bx[0]), .card2X(bx[1]), .card3X(bx[2]), .card4X(bx[3]), .card5X(bx[4]), .card6X(bx[5]),
    .card7X(bx[6]), .card8X(bx[7]), .card9X(bx[8]), .card10X(bx[9]), .card11X(bx[10]), .card12X(bx[11]),
    .card13X(bx[12]), .card14X(bx[13]), .card15X(bx[14]), .card16X(bx[15]),
    .card1Y(by[0]), .card2Y(by[1]), .card3Y(by[2]), .card4Y(by[3]), .card5Y(by[4]), .card6Y(by[5]),
    .card7Y(by[6]), .card8Y(by[7]), .card9Y(by[8]), .card10Y(by[9]), .card11Y(by[10]), .card12Y(by[11]),
    .card13Y(by[12]), .card14Y(by[13]), .card15Y(by[14]), .card16Y(by[15]),
    .c(c_b), .d(d_b), .e(e_b));

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference Fisher-Yates: one INIT cycle, one cycle per draw, one LOAD cycle
  function automatic logic [63:0] model_perm(input logic [15:0] seed, output int cycles);
    logic [15:0] l;
    logic [3:0]  p [16];
    logic [3:0]  k, m, r, t;
    logic [63:0] packed_p;
    l = (seed == 16'd0) ? 16'hACE1 : seed;
    for (int i = 0; i < 16; i++) p[i] = 4'(i);
    l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    cycles = 1;
    k = 4'd15;
    for (int it = 0; it < 5000; it++) begin
      cycles++;
      m = (k >= 8) ? 4'hF : (k >= 4) ? 4'h7 : (k >= 2) ? 4'h3 : 4'h1;
      r = l[3:0] & m;
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      if (r <= k) begin
        t = p[k]; p[k] = p[r]; p[r] = t;
        if (k == 4'd1) break;
        k = k - 4'd1;
      end
    end
    cycles++;
    for (int i = 0; i < 16; i++) packed_p[4*i +: 4] = p[i];
    return packed_p;
  endfunction

  function automatic logic [4:0] xy_to_slot(input logic [9:0] x, input logic [9:0] y);
    logic [2:0] col, row;
    case (x)
      10'd80: col = 3'd0;  10'd200: col = 3'd1;  10'd320: col = 3'd2;  10'd440: col = 3'd3;
      default: col = 3'd4;
    endcase
    case (y)
      10'd40: row = 3'd0;  10'd150: row = 3'd1;  10'd260: row = 3'd2;  10'd370: row = 3'd3;
      default: row = 3'd4;
    endcase
    if (col[2] || row[2]) return 5'h10;
    return {1'b0, row[1:0], col[1:0]};
  endfunction

  task automatic check_layout(input string tag, input int which, input logic [63:0] exp, input bit use_exp);
    logic [15:0] seen;
    logic [4:0]  s;
    logic [9:0]  x, y;
    seen = 16'd0;
    for (int i = 0; i < 16; i++) begin
      case (which)
        0:       begin x = ax[i]; y = ay[i]; end
        1:       begin x = zx[i]; y = zy[i]; end
        default: begin x = bx[i]; y = by[i]; end
      endcase
      s = xy_to_slot(x, y);
      if (use_exp) checkOutput($sformatf("%s card%0d slot", tag, i + 1), {11'd0, s}, {12'd0, exp[4*i +: 4]});
      if (!s[4]) seen[s[3:0]] = 1'b1;
    end
    checkOutput({tag, " distinct grid slots"}, seen, 16'hFFFF);
  endtask

  // Releases reset and runs every instance until its done flag, bounded by a cycle budget
  task automatic applyStimulus(input string tag);
    int na, nz, nb, busy_bad, both_bad, crun, cmax;
    logic [3:0] clast;
    na = 0; nz = 0; nb = 0; busy_bad = 0; both_bad = 0; crun = 1; cmax = 1;
    clast = c_z;
    rst_n = 1'b1;
    for (int n = 1; n <= 3000 && (na == 0 || nz == 0 || nb == 0); n++) begin
      @(negedge clk);
      if (na == 0) begin
        if (e_a === 1'b1) na = n;
        else if (d_a !== 1'b1) busy_bad++;
      end
      if (nz == 0 && e_z === 1'b1) nz = n;
      if (nb == 0 && e_b === 1'b1) nb = n;
      if (d_a === 1'b1 && e_a === 1'b1) both_bad++;
      if (c_z === clast) crun++;
      else crun = 1;
      if (crun > cmax) cmax = crun;
      clast = c_z;
    end
    checkOutput({tag, " cycles to done ACE1"}, 16'(na), 16'(cyc_a));
    checkOutput({tag, " cycles to done seed0"}, 16'(nz), 16'(cyc_a));
    checkOutput({tag, " cycles to done 1234"}, 16'(nb), 16'(cyc_b));
    checkOutput({tag, " busy gaps before done"}, 16'(busy_bad), 16'd0);
    checkOutput({tag, " busy and done overlap"}, 16'(both_bad), 16'd0);
    checkOutput({tag, " d after done"}, {15'd0, d_a}, 16'd0);
    checkOutput({tag, " seed0 c run <= 16"}, {15'd0, cmax <= 16}, 16'd1);
  endtask

  initial begin
    logic [63:0] bpk;
    logic [4:0]  s;
    int          nr;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset card1X", {6'd0, ax[0]}, 16'd80);
    checkOutput("reset card1Y", {6'd0, ay[0]}, 16'd40);
    checkOutput("reset card4X", {6'd0, ax[3]}, 16'd440);
    checkOutput("reset card4Y", {6'd0, ay[3]}, 16'd40);
    checkOutput("reset card13X", {6'd0, ax[12]}, 16'd80);
    checkOutput("reset card13Y", {6'd0, ay[12]}, 16'd370);
    checkOutput("reset card16X", {6'd0, ax[15]}, 16'd440);
    checkOutput("reset card16Y", {6'd0, ay[15]}, 16'd370);
    checkOutput("reset c ACE1", {12'd0, c_a}, 16'h1);
    checkOutput("reset c seed0", {12'd0, c_z}, 16'h1);
    checkOutput("reset c 1234", {12'd0, c_b}, 16'h4);
    checkOutput("reset d", {15'd0, d_a}, 16'd0);
    checkOutput("reset e", {15'd0, e_a}, 16'd0);

    perm_a = model_perm(16'hACE1, cyc_a);
    perm_b = model_perm(16'h1234, cyc_b);

    applyStimulus("run1");
    check_layout("run1 ACE1", 0, perm_a, 1'b1);
    check_layout("run1 seed0", 1, perm_a, 1'b1);
    check_layout("run1 1234", 2, perm_b, 1'b1);
    for (int i = 0; i < 16; i++) begin
      s = xy_to_slot(bx[i], by[i]);
      bpk[4*i +: 4] = s[3:0];
    end
    vectors++;
    assert (bpk !== perm_a) else begin
      miscompares++;
      $error("[TB] FAIL seed 1234 layout: observed %h expected anything but %h", bpk, perm_a);
    end

    for (int i = 0; i < 16; i++) begin snap_x[i] = ax[i]; snap_y[i] = ay[i]; end
    repeat (100) @(negedge clk);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("hold card%0d", i + 1), {ax[i], 6'd0} ^ {6'd0, ay[i]}, {snap_x[i], 6'd0} ^ {6'd0, snap_y[i]});
    checkOutput("hold e", {15'd0, e_a}, 16'd1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("mid-shuffle d busy", {15'd0, d_a}, 16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset d", {15'd0, d_a}, 16'd0);
    checkOutput("async reset e", {15'd0, e_a}, 16'd0);
    checkOutput("async reset card1X", {6'd0, ax[0]}, 16'd80);
    checkOutput("async reset card16Y", {6'd0, ay[15]}, 16'd370);
    @(negedge clk);
    applyStimulus("run2");
    check_layout("run2 ACE1", 0, perm_a, 1'b1);

`ifdef POSGEN_RESHUFFLE_EN
    for (int i = 0; i < 16; i++) begin snap_x[i] = ax[i]; snap_y[i] = ay[i]; end
    reshuffle = 1'b1;
    @(negedge clk);
    reshuffle = 1'b0;
    checkOutput("reshuffle e", {15'd0, e_a}, 16'd0);
    checkOutput("reshuffle d", {15'd0, d_a}, 16'd1);
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("reshuffle held card%0d", i + 1), {ax[i], 6'd0} ^ {6'd0, ay[i]}, {snap_x[i], 6'd0} ^ {6'd0, snap_y[i]});
    nr = 0;
    for (int n = 0; n < 3000 && e_a !== 1'b1; n++) begin
      @(negedge clk);
      nr = n;
    end
    checkOutput("reshuffle done", {15'd0, e_a}, 16'd1);
    checkOutput("reshuffle cycle budget", {15'd0, nr < 2999}, 16'd1);
    check_layout("reshuffle ACE1", 0, perm_a, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/card_pos_generator.md
Name: card_pos_generator

Overview:
Generates a random placement of 16 memory-game cards on a fixed 4x4 on-screen grid of 10-bit pixel coordinates.
- After reset it shuffles the 16 slots with an LFSR-driven Fisher-Yates permutation.
- It then publishes one X/Y coordinate pair per card to the VGA renderer and game logic.
- Debug outputs expose the random nibble, busy and done.

Parameters:
- SEED, 16'hACE1: LFSR seed; a value of 0 is replaced by 16'hACE1.
- X_ORIGIN, 80: X pixel of grid column 0.
- Y_ORIGIN, 40: Y pixel of grid row 0.
- X_PITCH, 120: X distance between columns.
- Y_PITCH, 110: Y distance between rows.

Ports:
- FPGA_Clk  in  1  system clock; all state changes on its rising edge.
- FPGA_Rst_n  in  1  asynchronous active-low reset.
- cardNX  out  10  X pixel of card N, N=1..16 (16 ports: card1X..card16X).
- cardNY  out  10  Y pixel of card N, N=1..16 (16 ports: card1Y..card16Y).
- c  out  4  current random nibble, equal to lfsr[3:0].
- d  out  1  shuffle busy.
- e  out  1  shuffle done; outputs are final.

Behaviour:
- Slot s (0..15) maps to a grid position: col = s[1:0], row = s[3:2]. X = X_ORIGIN + col*X_PITCH, Y = Y_ORIGIN + row*Y_PITCH. Arithmetic is done in 10 bits; parameter defaults must keep X and Y at or below 1023.
- State: perm[0..15] (4-bit slot per card), 16-bit Galois LFSR (taps 16,14,13,11), index k (4 bits), FSM {INIT, SHUFFLE, LOAD, DONE}.
- LFSR advances every cycle in every state except during reset. c = lfsr[3:0], combinational from the register.
- Reset values: perm[i]=i; k=15; lfsr=SEED (or 16'hACE1 if SEED is 0); state=INIT; d=0; e=0. Card N outputs hold slot N-1 coordinates (identity layout), e.g. card1=(80,40), card16=(440,370).
- INIT: next cycle go to SHUFFLE, d<=1.
- SHUFFLE, each cycle:
  - r = lfsr[3:0] & m, where m is the smallest all-ones mask with m >= k.
  - If r <= k: swap perm[k] and perm[r] (r==k is a legal no-op). If k==1, go to LOAD; otherwise k<=k-1.
  - If r > k: rejection; no change, retry next cycle.
- LOAD: register all 32 coordinate outputs from perm; d<=0, e<=1; go to DONE.
- DONE: hold all outputs indefinitely; e stays 1 until reset.
- Card outputs change only on reset or in the LOAD cycle, never while d=1.
- The permutation is fully deterministic for a given SEED, counting from reset release.
- Reset asserted mid-shuffle immediately restores all reset values; the shuffle restarts from INIT after release.
- Invariant: d and e are never both 1.

Optional Feature:
- Macro POSGEN_RESHUFFLE_EN.
- When defined: adds input port reshuffle (1 bit, placed after FPGA_Rst_n).
  - A reshuffle=1 in DONE sets k=15, e<=0, d<=1 and enters SHUFFLE, continuing from the current perm and LFSR state.
  - Card outputs keep the previous layout until the next LOAD.
  - reshuffle is ignored in any other state.
- When undefined: no reshuffle port; DONE is terminal until reset.

Decomposition:
- Package pos_gen_pkg holds:
  - the FSM state enum;
  - typedef slot_t (4 bits) and coord_t (10 bits);
  - LFSR_TAPS and DEFAULT_SEED constants;
  - a function slot_to_xy(slot, origins, pitches).
- One sub-module, pos_lfsr16: seed load on reset, free-running step, exposes the 16-bit state.

Test Plan:
- Reset asserted: card1=(80,40), card4=(440,40), card13=(80,370), card16=(440,370); c=SEED[3:0]=4'h1; d=0; e=0.
- Release reset and run to e=1:
  - d=1 from the second cycle until LOAD;
  - all 16 (X,Y) pairs are distinct and each lies in {80,200,320,440}x{40,150,260,370};
  - outputs are unchanged in the 100 cycles after e rose.
- Run two shuffles from reset with SEED=16'hACE1: identical final coordinate sets card by card and identical cycle count to e=1. SEED=16'h1234 gives a different layout.
- Assert reset while d=1, mid-shuffle: d=0, e=0 and identity layout immediately (asynchronous, before the next clock edge); after release a full shuffle completes again.
- SEED=0: LFSR loads 16'hACE1, c never stays constant for more than 16 cycles, and the shuffle terminates.
- POSGEN_RESHUFFLE_EN: pulse reshuffle one cycle in DONE: e=0, d=1 next cycle, old layout held; on completion a new valid permutation appears and e=1.
